// File: rtl/serial_arith_pkg.sv
// ---------------------------------------------------------------------------
// serial_arith_pkg
// Shared types and helpers for the bit-serial arithmetic blocks.
//   ser_state_t : operation state of a serial arithmetic unit
//   cnt_width() : width of a bit counter able to index 0..width-1
// ---------------------------------------------------------------------------
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } ser_state_t;

    // A one-bit counter is still needed when the operand is a single bit wide
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/subtractor_1bit.sv
// ---------------------------------------------------------------------------
// subtractor_1bit
// Combinational full subtractor: computes a - b - borrow_in for one bit.
//   a          in  minuend bit
//   b          in  subtrahend bit
//   borrow_in  in  borrow from the less significant bit
//   diff       out difference bit
//   borrow_out out borrow into the more significant bit
// ---------------------------------------------------------------------------
module subtractor_1bit (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    // The outputs and their self-checks live in one block so the checks
    // always see a settled diff/borrow pair rather than a mid-update mix.
    always_comb begin
        diff       = a ^ b ^ borrow_in;
        borrow_out = (~a & b) | (~(a ^ b) & borrow_in);
        if (!$isunknown({a, b, borrow_in})) begin
            // Difference bit is the parity of the three inputs
            assert (diff == (a ^ b ^ borrow_in));
            // a - b - borrow_in lies in -2..1, so modulo 4 it must equal
            // the two-bit value {borrow_out, diff}
            assert ((2'(a) - 2'(b) - 2'(borrow_in)) == {borrow_out, diff});
        end
    end

endmodule

// File: rtl/serial_subtractor_nbit.sv
// ---------------------------------------------------------------------------
// serial_subtractor_nbit
// Bit-serial subtractor: a - b - borrow_in, one bit per clock, LSB first.
//   clk        in  system clock, rising edge
//   n_rst      in  asynchronous active-low reset
//   start      in  launch request, honoured in IDLE or DONE
//   a, b       in  minuend / subtrahend, latched on an accepted start
//   borrow_in  in  initial borrow, latched on an accepted start
//   busy       out high while bits are being processed
//   done       out one-cycle pulse when the result is valid
//   diff       out result modulo 2^BIT_WIDTH, held until the next result
//   borrow_out out borrow out of the MSB
//   overflow   out signed overflow (borrow into MSB xor borrow out of MSB)
// ---------------------------------------------------------------------------
module serial_subtractor_nbit
    import serial_arith_pkg::*;
#(
    parameter int BIT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 borrow_in,
    output logic                 busy,
    output logic                 done,
    output logic [BIT_WIDTH-1:0] diff,
    output logic                 borrow_out,
    output logic                 overflow
);

    localparam int CNT_W = cnt_width(BIT_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_WIDTH - 1);

    ser_state_t           r_state;
    logic [BIT_WIDTH-1:0] r_a;
    logic [BIT_WIDTH-1:0] r_b;
    logic [BIT_WIDTH-1:0] r_res;
    logic                 r_br;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [BIT_WIDTH-1:0] r_diff;
    logic                 r_borrow_out;
    logic                 r_overflow;

    logic w_d;
    logic w_br_next;
    logic w_last;
    logic w_accept;

    // The single arithmetic cell always looks at the current LSBs and the
    // running borrow; the FSM decides whether its result is used.
    subtractor_1bit u_sub (
        .a          (r_a[0]),
        .b          (r_b[0]),
        .borrow_in  (r_br),
        .diff       (w_d),
        .borrow_out (w_br_next)
    );

    assign w_last   = (r_cnt == LAST_CNT);
    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));

    // Control FSM and datapath. Result bits enter the result register at
    // the MSB end, so after BIT_WIDTH shifts the first bit sits at bit 0.
    // The visible outputs are only written on the final bit so partial
    // shift contents never show on diff.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_res        <= '0;
            r_br         <= 1'b0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= BUSY;
                        r_busy  <= 1'b1;
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= borrow_in;
                        r_cnt   <= '0;
                        r_res   <= '0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                BUSY: begin
                    r_res <= {w_d, r_res[BIT_WIDTH-1:1]};
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_br_next;
                    if (w_last) begin
                        r_state      <= DONE;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_diff       <= {w_d, r_res[BIT_WIDTH-1:1]};
                        r_borrow_out <= w_br_next;
                        // r_br is the borrow into the MSB at this edge
                        r_overflow   <= r_br ^ w_br_next;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Unknown operand bits at an accepted start would silently corrupt the
    // result, so flag each offending bit by index.
    always_ff @(posedge clk) begin
        if (n_rst && w_accept) begin
            for (int i = 0; i < BIT_WIDTH; i++) begin
                assert (!$isunknown(a[i])) else $error("a[%0d] is X/Z at accepted start", i);
                assert (!$isunknown(b[i])) else $error("b[%0d] is X/Z at accepted start", i);
            end
            assert (!$isunknown(borrow_in)) else $error("borrow_in is X/Z at accepted start");
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor_nbit
// Directed bench for the bit-serial subtractor: a 4-bit instance for the
// protocol scenarios and an 8-bit instance for a table of wider operands.
// ---------------------------------------------------------------------------
module tb_serial_subtractor_nbit;

    logic       clk;
    logic       n_rst;

    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       borrow_in;
    logic       busy;
    logic       done;
    logic [3:0] diff;
    logic       borrowOut;
    logic       overflow;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       borrowIn8;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       borrowOut8;
    logic       overflow8;

    int compared;
    int mismatched;

    serial_subtractor_nbit #(.BIT_WIDTH(4)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrowOut),
        .overflow   (overflow)
    );

    serial_subtractor_nbit #(.BIT_WIDTH(8)) dut8 (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start8),
        .a          (a8),
        .b          (b8),
        .borrow_in  (borrowIn8),
        .busy       (busy8),
        .done       (done8),
        .diff       (diff8),
        .borrow_out (borrowOut8),
        .overflow   (overflow8)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Launch one 4-bit operation and wait (bounded) for its done pulse;
    // returns at the negedge where done is seen.
    task automatic run_op(input logic [3:0] av, input logic [3:0] bv, input logic bi,
                          output int busyCycles, output bit gotDone);
        @(negedge clk);
        a = av; b = bv; borrow_in = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busyCycles = 0;
        gotDone = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                gotDone = 1'b1;
                break;
            end
            if (busy) busyCycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        compared += 5;
        if (busy !== 1'b0)      begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0)      begin mismatched++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        if (diff !== 4'd0)      begin mismatched++; $display("[TB] FAIL reset_diff: got %0d expected 0", diff); end
        if (borrowOut !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_borrow_out: got %b expected 0", borrowOut); end
        if (overflow !== 1'b0)  begin mismatched++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_vectors();
        logic [3:0] va [4];
        logic [3:0] vb [4];
        logic       vbi [4];
        logic [3:0] vd [4];
        logic       vbo [4];
        logic       vov [4];
        int         busyCycles;
        bit         gotDone;
        va  = '{4'd5, 4'd3, 4'd8, 4'd0};
        vb  = '{4'd3, 4'd5, 4'd1, 4'd0};
        vbi = '{1'b0, 1'b0, 1'b0, 1'b1};
        vd  = '{4'd2, 4'd14, 4'd7, 4'd15};
        vbo = '{1'b0, 1'b1, 1'b0, 1'b1};
        vov = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int t = 0; t < 4; t++) begin
            run_op(va[t], vb[t], vbi[t], busyCycles, gotDone);
            compared += 6;
            if (gotDone !== 1'b1)  begin mismatched++; $display("[TB] FAIL vec%0d_done_timeout: got %b expected 1", t, gotDone); end
            if (busyCycles != 4)   begin mismatched++; $display("[TB] FAIL vec%0d_busy_cycles: got %0d expected 4", t, busyCycles); end
            if (diff !== vd[t])    begin mismatched++; $display("[TB] FAIL vec%0d_diff: got %0d expected %0d", t, diff, vd[t]); end
            if (borrowOut !== vbo[t]) begin mismatched++; $display("[TB] FAIL vec%0d_borrow_out: got %b expected %b", t, borrowOut, vbo[t]); end
            if (overflow !== vov[t])  begin mismatched++; $display("[TB] FAIL vec%0d_overflow: got %b expected %b", t, overflow, vov[t]); end
            @(negedge clk);
            if (done !== 1'b0)     begin mismatched++; $display("[TB] FAIL vec%0d_done_width: got %b expected 0", t, done); end
        end
    endtask

    task automatic test_busy_ignore();
        int         doneCount;
        logic [3:0] seenDiff;
        seenDiff = 4'd0;
        doneCount = 0;
        @(negedge clk);
        a = 4'd9; b = 4'd4; borrow_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 4'd1; b = 4'd1; borrow_in = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) begin
                doneCount++;
                seenDiff = diff;
            end
        end
        compared += 3;
        if (doneCount != 1)      begin mismatched++; $display("[TB] FAIL busy_done_count: got %0d expected 1", doneCount); end
        if (seenDiff !== 4'd5)   begin mismatched++; $display("[TB] FAIL busy_diff: got %0d expected 5", seenDiff); end
        if (borrowOut !== 1'b0)  begin mismatched++; $display("[TB] FAIL busy_borrow_out: got %b expected 0", borrowOut); end
    endtask

    task automatic test_reset_mid_op();
        int busyCycles;
        bit gotDone;
        int doneCount;
        @(negedge clk);
        a = 4'd6; b = 4'd2; borrow_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        compared += 3;
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
        if (diff !== 4'd0) begin mismatched++; $display("[TB] FAIL midrst_diff: got %0d expected 0", diff); end
        if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_done: got %b expected 0", done); end
        @(negedge clk);
        n_rst = 1'b1;
        doneCount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) doneCount++;
        end
        compared += 2;
        if (doneCount != 0) begin mismatched++; $display("[TB] FAIL midrst_no_done: got %0d expected 0", doneCount); end
        if (busy !== 1'b0)  begin mismatched++; $display("[TB] FAIL midrst_idle: got %b expected 0", busy); end
        run_op(4'd7, 4'd4, 1'b0, busyCycles, gotDone);
        compared += 2;
        if (gotDone !== 1'b1) begin mismatched++; $display("[TB] FAIL midrst_recover_done: got %b expected 1", gotDone); end
        if (diff !== 4'd3)    begin mismatched++; $display("[TB] FAIL midrst_recover_diff: got %0d expected 3", diff); end
    endtask

    task automatic test_back_to_back();
        int doneAt[$];
        int badDiff;
        badDiff = 0;
        @(negedge clk);
        a = 4'd12; b = 4'd3; borrow_in = 1'b0; start = 1'b1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            if (done) begin
                doneAt.push_back(cyc);
                if (diff !== 4'd9) badDiff++;
            end
        end
        start = 1'b0;
        compared += 2;
        if (doneAt.size() != 3) begin mismatched++; $display("[TB] FAIL b2b_done_count: got %0d expected 3", doneAt.size()); end
        if (badDiff != 0)       begin mismatched++; $display("[TB] FAIL b2b_diff: got %0d wrong results expected 0", badDiff); end
        if (doneAt.size() == 3) begin
            compared += 3;
            if (doneAt[0] != 4) begin mismatched++; $display("[TB] FAIL b2b_first_done: got cycle %0d expected 4", doneAt[0]); end
            if (doneAt[1] - doneAt[0] != 5) begin mismatched++; $display("[TB] FAIL b2b_spacing1: got %0d expected 5", doneAt[1] - doneAt[0]); end
            if (doneAt[2] - doneAt[1] != 5) begin mismatched++; $display("[TB] FAIL b2b_spacing2: got %0d expected 5", doneAt[2] - doneAt[1]); end
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_sweep8();
        logic [7:0] va [6];
        logic [7:0] vb [6];
        logic       vbi [6];
        logic [7:0] vd [6];
        logic       vbo [6];
        logic       vov [6];
        int         busyCycles;
        bit         gotDone;
        va  = '{8'd200, 8'd55,  8'd128, 8'd127, 8'd0,   8'd170};
        vb  = '{8'd55,  8'd200, 8'd1,   8'd255, 8'd0,   8'd85};
        vbi = '{1'b0,   1'b1,   1'b0,   1'b0,   1'b1,   1'b1};
        vd  = '{8'd145, 8'd110, 8'd127, 8'd128, 8'd255, 8'd84};
        vbo = '{1'b0,   1'b1,   1'b0,   1'b1,   1'b1,   1'b0};
        vov = '{1'b0,   1'b0,   1'b1,   1'b1,   1'b0,   1'b1};
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            a8 = va[t]; b8 = vb[t]; borrowIn8 = vbi[t]; start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0;
            busyCycles = 0;
            gotDone = 1'b0;
            for (int i = 0; i < 30; i++) begin
                if (done8) begin
                    gotDone = 1'b1;
                    break;
                end
                if (busy8) busyCycles++;
                @(negedge clk);
            end
            compared += 5;
            if (gotDone !== 1'b1)       begin mismatched++; $display("[TB] FAIL sweep%0d_done_timeout: got %b expected 1", t, gotDone); end
            if (busyCycles != 8)        begin mismatched++; $display("[TB] FAIL sweep%0d_busy_cycles: got %0d expected 8", t, busyCycles); end
            if (diff8 !== vd[t])        begin mismatched++; $display("[TB] FAIL sweep%0d_diff: got %0d expected %0d", t, diff8, vd[t]); end
            if (borrowOut8 !== vbo[t])  begin mismatched++; $display("[TB] FAIL sweep%0d_borrow_out: got %b expected %b", t, borrowOut8, vbo[t]); end
            if (overflow8 !== vov[t])   begin mismatched++; $display("[TB] FAIL sweep%0d_overflow: got %b expected %b", t, overflow8, vov[t]); end
        end
    endtask

    // Scenario sequence
    initial begin
        compared   = 0;
        mismatched = 0;
        n_rst      = 1'b1;
        start      = 1'b0;
        a          = 4'd0;
        b          = 4'd0;
        borrow_in  = 1'b0;
        start8     = 1'b0;
        a8         = 8'd0;
        b8         = 8'd0;
        borrowIn8  = 1'b0;
        #2;
        n_rst = 1'b0;

        test_reset();
        test_vectors();
        test_busy_ignore();
        test_reset_mid_op();
        test_back_to_back();
        test_sweep8();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
